distance_averager: RTL

- Upstream stage of the Cyclone Cruiser scaling multiplier: averages N ultrasonic distance samples taken at one servo position.
- Emits a signed 32-bit average distance in millimetres that feeds the sine/cosine fixed-point multiplier directly.
- Rejects invalid echoes (0 mm, or above the range limit) so they never enter the average.
- Uses a ready/valid handshake on both input and output.

---
 rtl/radar_pkg.sv | 18 +
 rtl/distance_averager.sv | 112 +++++++++++
 2 files changed

// File: rtl/radar_pkg.sv
// Constants and types shared by the ultrasonic front end and the
// distance/fixed-point multiplier path of the Cyclone Cruiser.
package radar_pkg;

  localparam int DIST_W = 16;
  localparam int MAX_MM = 4000;

  // Signed distance word fed straight into the sine/cosine multiplier.
  typedef logic signed [31:0] dist_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/distance_averager.sv
// Averages N_SAMPLES in-range ultrasonic echoes taken at one servo position
// and presents the mean distance through a ready/valid output.
module distance_averager #(
  parameter int N_SAMPLES = 4,
  parameter int LOG2_N    = 2,
  parameter int DIST_W    = radar_pkg::DIST_W,
  parameter int MAX_MM    = radar_pkg::MAX_MM
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DIST_W-1:0] sample_mm,
  output logic              sample_ready,
  output logic [31:0]       avg_dist,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              busy,
  output logic [7:0]        rejected_cnt
);

  import radar_pkg::*;

  localparam int ACC_W = DIST_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [DIST_W-1:0] MAX_V  = DIST_W'(MAX_MM);
  localparam logic [CNT_W-1:0]  LAST_V = CNT_W'(N_SAMPLES - 1);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [7:0]         rej_reg, rej_next;
  dist_t              avg_reg, avg_next;
  logic               avg_valid_reg, avg_valid_next;
  logic               in_range;

  assign in_range = (sample_mm != '0) && (sample_mm <= MAX_V);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      rej_reg       <= '0;
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      rej_reg       <= rej_next;
      avg_reg       <= avg_next;
      avg_valid_reg <= avg_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    rej_next       = rej_reg;
    avg_next       = avg_reg;
    avg_valid_next = avg_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = '0;
          cnt_next   = '0;
          rej_next   = '0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        // A restart takes priority over any sample arriving on the same edge.
        if (start) begin
          acc_next = '0;
          cnt_next = '0;
          rej_next = '0;
        end else if (sample_valid) begin
          if (in_range) begin
            acc_next = acc_reg + ACC_W'(sample_mm);
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_V) begin
              state_next = DIVIDE;
            end
          end else if (rej_reg != 8'hFF) begin
            rej_next = rej_reg + 8'd1;
          end
        end
      end
      DIVIDE: begin
        avg_next       = dist_t'(acc_reg >> LOG2_N);
        avg_valid_next = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        if (avg_ready) begin
          avg_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sample_ready = (state_reg == ACCUM);
  assign busy         = (state_reg != IDLE);
  assign avg_dist     = avg_reg;
  assign avg_valid    = avg_valid_reg;
  assign rejected_cnt = rej_reg;

endmodule
